fifo_fwft_ctrl: RTL and testbench
=================================

// Module: fifo_fwft_ctrl
// PURPOSE
//  Pointer/flag controller that sequences the dual-port RAM as a first-word-fall-through FIFO
//  - Owns the write and read pointers, the RAM write enable and the status flags
//  - The RAM read port is combinational, so the head word sits on rd_data while empty=0
//  - Sits between the range-sensor capture logic (writer) and the bus read interface (reader)
// PARAMETERS
//  ADDR_WIDTH  4                 RAM address bits; FIFO depth DEPTH = 2**ADDR_WIDTH
//  AF_LEVEL    2**ADDR_WIDTH-2   almost_full asserts when count >= AF_LEVEL
// PORTS
//  clk          in   1             single clock; all logic on posedge
//  rst_n        in   1             asynchronous, active-low reset
//  clr          in   1             synchronous flush; empties FIFO, clears sticky errors
//  wr           in   1             write request; data is presented to RAM by the writer
//  rd           in   1             read/pop request; head word is consumed this cycle
//  ram_wr_en    out  1             RAM write enable (= accepted write)
//  ram_wr_addr  out  ADDR_WIDTH    RAM write address
//  ram_rd_addr  out  ADDR_WIDTH    RAM read address (head of FIFO)
//  empty        out  1             no valid word; rd_data is undefined
//  full         out  1             DEPTH words stored
//  almost_full  out  1             count >= AF_LEVEL
//  count        out  ADDR_WIDTH+1  words stored, 0..DEPTH
//  overflow     out  1             sticky: write dropped while full
//  underflow    out  1             sticky: read requested while empty
// BEHAVIOUR
//  - Reset (rst_n=0, async): both pointers=0, count=0, empty=1, full=0, almost_full=0
//    (unless AF_LEVEL=0), overflow=0, underflow=0, ram_wr_en=0. RAM contents are not cleared.
//  - Pointers wr_ptr/rd_ptr are ADDR_WIDTH+1 bits
//    - low ADDR_WIDTH bits drive the RAM addresses
//    - MSB is the wrap bit; all increments are modulo 2**(ADDR_WIDTH+1)
//  - Flags
//    - empty = (wr_ptr == rd_ptr)
//    - full  = MSBs differ and low bits are equal
//    - count = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1)
//  - Flags are derived from registered pointers and change the cycle after the edge that moves them
//  - Accept rules, evaluated combinationally each cycle:
//    - wr_ok = wr & (~full | rd): a simultaneous read frees a slot when full
//    - rd_ok = rd & ~empty: no bypass; a word written into an empty FIFO is visible one cycle later
//  - ram_wr_en = wr_ok & ~clr. On the posedge, wr_ok advances wr_ptr and rd_ok advances rd_ptr.
//  - Latency: write at edge N -> empty=0 and head valid after edge N. Pop at edge N -> next head after edge N.
//  - Simultaneous wr_ok & rd_ok: both pointers advance and count is unchanged
//  - Full & wr & rd: both are accepted
//  - Full & wr & ~rd: the write is dropped, pointers hold, overflow<=1
//  - Empty & rd: the read is ignored and underflow<=1
//  - Empty & rd & wr: the write is accepted, the read is ignored and underflow<=1
//  - clr has priority over wr and rd:
//    - rd_ptr <= wr_ptr (no data written that cycle); the FIFO is empty next cycle
//    - overflow and underflow are cleared
//  - Wrap-around: after 2**(ADDR_WIDTH+1) accepted writes the pointers alias correctly
//  - rst_n asserted mid-operation aborts immediately; pending RAM data is discarded logically
//  - The controller never addresses RAM locations >= DEPTH
// STRUCTURE
//  - Shared package fifo_pkg holds:
//    - function clog2-free DEPTH calc
//    - typedef ptr_t (ADDR_WIDTH+1 bits)
//    - default AF_LEVEL constant
//  - One natural sub-module, fifo_ptr: a wrap-bit pointer register with async reset, inc and load inputs
//    - instantiated twice: write and read pointers
//  - Top-level wrapper fifo_fwft pairs this controller with the existing RAM
//    - it is built separately and is not part of this block
// TESTING (ADDR_WIDTH=4, DEPTH=16, AF_LEVEL=14; bench includes RAM model)
//  1 Reset, then 1 write of 0xA5 -> next cycle empty=0, count=1, rd_data=0xA5; pop -> empty=1, count=0
//  2 16 writes 0x00..0x0F, no reads -> full=1, count=16, almost_full=1 from count 14;
//    17th write -> ignored, overflow=1, count=16
//  3 Full, then wr & rd in the same cycle with data 0x10 -> popped 0x00, count stays 16;
//    drain -> 0x01..0x0F, then 0x10 in order
//  4 Empty FIFO, rd=1 -> underflow=1, pointers hold; then clr -> underflow=0, overflow=0
//  5 Stream 40 words with continuous wr&rd after priming 3 words
//    -> in-order data across 2+ pointer wraps, count constant 3
//  6 Write 5 words, assert rst_n=0 mid-cycle (async)
//    -> empty=1, count=0 immediately; clr with wr=1 -> ram_wr_en=0, FIFO empty next cycle

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the first-word-fall-through FIFO controller.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 4;

  // Depth from address bits without relying on $clog2.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  localparam int DEF_AF_LEVEL = fifo_depth(DEF_ADDR_WIDTH) - 2;

  typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register: the MSB toggles each time the address field wraps.
module fifo_ptr #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic                  load,
  input  logic [ADDR_WIDTH:0]   load_val,
  output logic [ADDR_WIDTH:0]   ptr
);

  // Load wins over increment so a flush cannot be undone by a same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_fwft_ctrl.sv
// Pointer/flag controller that runs a dual-port RAM with a combinational read port
// as a first-word-fall-through FIFO.
module fifo_fwft_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH + 1)'(AF_LEVEL);

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                wr_ok;
  logic                rd_ok;

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                       (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign count       = wr_ptr - rd_ptr;
  assign almost_full = (count >= AF_LVL);

  // A pop in the same cycle frees the slot the write needs when full.
  assign wr_ok = wr & (~full | rd);
  assign rd_ok = rd & ~empty;

  // Gated by rst_n so the RAM never sees a write strobe while the pointers are held.
  assign ram_wr_en   = wr_ok & ~clr & rst_n;
  assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (wr_ok & ~clr),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (wr_ptr)
  );

  // Flush by snapping the read pointer onto the write pointer.
  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (rd_ok),
    .load     (clr),
    .load_val (wr_ptr),
    .ptr      (rd_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full && !rd) overflow  <= 1'b1;
      if (rd && empty)       underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_fwft_ctrl.sv
// Scoreboard bench for fifo_fwft_ctrl with a behavioural 16x8 RAM attached.
module tb_fifo_fwft_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       wr;
  logic       rd;
  logic       ram_wr_en;
  logic [3:0] ram_wr_addr;
  logic [3:0] ram_rd_addr;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic [7:0] mem [16];

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  fifo_fwft_ctrl #(.ADDR_WIDTH(4), .AF_LEVEL(14)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .wr          (wr),
    .rd          (rd),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_rd_addr (ram_rd_addr),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= wr_data;
  assign rd_data = mem[ram_rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must present the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && rd && !empty) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_data: got %0h, expected nothing queued", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL pop_data: got %0h, expected %0h", rd_data, e);
        end
      end
    end
  end

  task automatic cyc(input logic w, input logic r, input logic c, input logic [7:0] d);
    wr = w; rd = r; clr = c; wr_data = d;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  task automatic pop(input logic [7:0] e);
    exp_q.push_back(e);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; wr_data = 8'h00;
    #12;
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    chk("rst_wren", ram_wr_en, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single word falls through
    cyc(1'b1, 1'b0, 1'b0, 8'hA5);
    chk("t1_empty", empty, 0);
    chk("t1_count", count, 1);
    chk("t1_head", rd_data, 8'hA5);
    pop(8'hA5);
    chk("t1_empty_after", empty, 1);
    chk("t1_count_after", count, 0);

    // 2: fill to full, almost_full from 14, overflow on 17th
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'(i));
      chk("t2_af", almost_full, (i + 1 >= 14) ? 1 : 0);
    end
    chk("t2_full", full, 1);
    chk("t2_count", count, 16);
    chk("t2_ovf_clear", overflow, 0);
    cyc(1'b1, 1'b0, 1'b0, 8'h99);
    chk("t2_ovf", overflow, 1);
    chk("t2_count_hold", count, 16);
    chk("t2_full_hold", full, 1);

    // 3: write+read while full, then drain in order
    exp_q.push_back(8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'h10);
    chk("t3_count", count, 16);
    chk("t3_full", full, 1);
    for (int i = 1; i <= 16; i++) pop(8'(i));
    chk("t3_empty", empty, 1);
    chk("t3_ovf_sticky", overflow, 1);

    // 4: underflow, sticky behaviour and clr
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t4_udf", underflow, 1);
    chk("t4_count", count, 0);
    chk("t4_empty", empty, 1);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk("t4_udf_clr", underflow, 0);
    chk("t4_ovf_clr", overflow, 0);
    cyc(1'b1, 1'b1, 1'b0, 8'h55);
    chk("t4_udf_wr", underflow, 1);
    chk("t4_count_wr", count, 1);
    pop(8'h55);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk("t4_udf_clr2", underflow, 0);

    // 5: streaming across pointer wraps
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(8'(8'h20 + i));
      cyc(1'b1, 1'b1, 1'b0, 8'(8'h23 + i));
      chk("t5_count", count, 3);
    end
    pop(8'h48); pop(8'h49); pop(8'h4A);
    chk("t5_empty", empty, 1);

    // 6: async reset mid-cycle, then clr overriding a write
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
    chk("t6_count_pre", count, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_count", count, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, 1'b0, 1'b0, 8'h70);
    cyc(1'b1, 1'b0, 1'b0, 8'h71);
    chk("t6_count2", count, 2);
    wr = 1'b1; clr = 1'b1; wr_data = 8'h72;
    #1;
    chk("t6_clr_wren", ram_wr_en, 0);
    @(posedge clk); #1;
    wr = 1'b0; clr = 1'b0;
    chk("t6_clr_empty", empty, 1);
    chk("t6_clr_count", count, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
